// File: rtl/ga_pkg.sv
// Shared constants, FSM encoding and helpers for the GA fitness path.
// Chromosome layout: gene k occupies chrom[GENE_W*k +: GENE_W].
package ga_pkg;

    localparam int N_CITIES = 30;
    localparam int GENE_W   = 5;
    localparam int CHROM_W  = N_CITIES * GENE_W;
    localparam int COORD_W  = 8;
    localparam int DIST_W   = 16;

    localparam logic [GENE_W-1:0] N_CITIES_G = GENE_W'(N_CITIES);
    localparam logic [GENE_W-1:0] LAST_IDX   = GENE_W'(N_CITIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_ACCUM,
        S_CLOSE,
        S_DONE
    } state_t;

    function automatic logic [GENE_W-1:0] gene_at(
        input logic [CHROM_W-1:0] c,
        input logic [GENE_W-1:0]  k
    );
        return c[GENE_W*k +: GENE_W];
    endfunction

    function automatic logic [COORD_W:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

endpackage

// File: rtl/coord_table.sv
// City coordinate register file: one write port, one combinational read.
// Reads of indices beyond the table return the origin.
module coord_table
    import ga_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [GENE_W-1:0]  wr_addr,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [GENE_W-1:0]  rd_addr,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y
);

    logic [COORD_W-1:0] xs [N_CITIES];
    logic [COORD_W-1:0] ys [N_CITIES];

    // Table storage; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CITIES; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else if (we && (wr_addr < N_CITIES_G)) begin
            xs[wr_addr] <= wr_x;
            ys[wr_addr] <= wr_y;
        end
    end

    // Combinational read, origin for nonexistent cities.
    always_comb begin
        rd_x = '0;
        rd_y = '0;
        if (rd_addr < N_CITIES_G) begin
            rd_x = xs[rd_addr];
            rd_y = ys[rd_addr];
        end
    end

endmodule

// File: rtl/route_fitness.sv
// Closed-tour Manhattan distance and permutation check for one chromosome.
// One gene per cycle; result and done pulse registered at the end.
module route_fitness
    import ga_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [GENE_W-1:0]  cfg_addr,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic               start,
    input  logic [CHROM_W-1:0] chrom,
    output logic               busy,
    output logic [DIST_W-1:0]  distance,
    output logic               valid,
    output logic               done
);

    state_t              state;
    logic [CHROM_W-1:0]  chrom_q;
    logic [GENE_W-1:0]   idx;
    logic [GENE_W-1:0]   gene;
    logic [N_CITIES-1:0] seen;
    logic                bad;
    logic                gene_ok;
    logic                gene_bad;
    logic                tbl_we;
    logic [DIST_W-1:0]   acc;
    logic [DIST_W-1:0]   acc_close;
    logic [COORD_W-1:0]  cur_x;
    logic [COORD_W-1:0]  cur_y;
    logic [COORD_W-1:0]  prev_x;
    logic [COORD_W-1:0]  prev_y;
    logic [COORD_W-1:0]  first_x;
    logic [COORD_W-1:0]  first_y;
    logic [COORD_W:0]    leg_step;
    logic [COORD_W:0]    leg_close;

    assign gene      = gene_at(chrom_q, idx);
    assign gene_ok   = gene < N_CITIES_G;
    assign gene_bad  = !gene_ok || seen[gene];
    assign tbl_we    = cfg_we && (state == S_IDLE);
    assign leg_step  = abs_diff(cur_x, prev_x) + abs_diff(cur_y, prev_y);
    assign leg_close = abs_diff(first_x, prev_x) + abs_diff(first_y, prev_y);
    assign acc_close = acc + DIST_W'(leg_close);

    coord_table u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (tbl_we),
        .wr_addr (cfg_addr),
        .wr_x    (cfg_x),
        .wr_y    (cfg_y),
        .rd_addr (gene),
        .rd_x    (cur_x),
        .rd_y    (cur_y)
    );

    // Evaluation FSM: walk the tour, accumulate legs, track duplicates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            chrom_q  <= '0;
            idx      <= '0;
            seen     <= '0;
            bad      <= 1'b0;
            acc      <= '0;
            prev_x   <= '0;
            prev_y   <= '0;
            first_x  <= '0;
            first_y  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            distance <= '0;
            valid    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        chrom_q <= chrom;
                        idx     <= '0;
                        seen    <= '0;
                        bad     <= 1'b0;
                        acc     <= '0;
                        busy    <= 1'b1;
                        state   <= S_FIRST;
                    end
                end
                S_FIRST: begin
                    first_x <= cur_x;
                    first_y <= cur_y;
                    prev_x  <= cur_x;
                    prev_y  <= cur_y;
                    if (gene_ok) seen[gene] <= 1'b1;
                    if (gene_bad) bad <= 1'b1;
                    idx   <= idx + 1'b1;
                    state <= S_ACCUM;
                end
                S_ACCUM: begin
                    acc    <= acc + DIST_W'(leg_step);
                    prev_x <= cur_x;
                    prev_y <= cur_y;
                    if (gene_ok) seen[gene] <= 1'b1;
                    if (gene_bad) bad <= 1'b1;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) state <= S_CLOSE;
                end
                S_CLOSE: begin
                    acc      <= acc_close;
                    distance <= acc_close;
                    valid    <= !bad && (&seen);
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_route_fitness.sv
// Self-checking bench for route_fitness: vector table, corner sequences
// and randomized tours against a reference model of the tour length.
module tb_route_fitness;
    import ga_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [GENE_W-1:0]  cfg_addr;
    logic [COORD_W-1:0] cfg_x;
    logic [COORD_W-1:0] cfg_y;
    logic               start;
    logic [CHROM_W-1:0] chrom;
    logic               busy;
    logic [DIST_W-1:0]  distance;
    logic               valid;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_x [32];
    int tb_y [32];

    typedef struct {
        string              name;
        int                 mode;
        logic [CHROM_W-1:0] c;
        int                 exp_d;
        int                 exp_v;
    } vec_t;

    vec_t vecs [8];

    route_fitness dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_x    (cfg_x),
        .cfg_y    (cfg_y),
        .start    (start),
        .chrom    (chrom),
        .busy     (busy),
        .distance (distance),
        .valid    (valid),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [CHROM_W-1:0] set_gene(
        input logic [CHROM_W-1:0] c, input int k, input int g);
        logic [CHROM_W-1:0] r;
        r = c;
        r[GENE_W*k +: GENE_W] = GENE_W'(g);
        return r;
    endfunction

    function automatic logic [CHROM_W-1:0] ident();
        logic [CHROM_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CITIES; k++) r = set_gene(r, k, k);
        return r;
    endfunction

    function automatic logic [CHROM_W-1:0] reversed();
        logic [CHROM_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CITIES; k++) r = set_gene(r, k, N_CITIES - 1 - k);
        return r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Tour length: visit genes in order, then return to the first city.
    function automatic int model_dist(input logic [CHROM_W-1:0] c);
        int g [N_CITIES];
        int sum;
        int a;
        int b;
        for (int k = 0; k < N_CITIES; k++) g[k] = int'(c[GENE_W*k +: GENE_W]);
        sum = 0;
        for (int k = 0; k < N_CITIES; k++) begin
            a = g[k];
            b = g[(k + 1) % N_CITIES];
            sum += iabs(tb_x[a] - tb_x[b]) + iabs(tb_y[a] - tb_y[b]);
        end
        return sum;
    endfunction

    // Valid when every city appears exactly once.
    function automatic int model_valid(input logic [CHROM_W-1:0] c);
        int occ [32];
        for (int i = 0; i < 32; i++) occ[i] = 0;
        for (int k = 0; k < N_CITIES; k++) occ[int'(c[GENE_W*k +: GENE_W])]++;
        for (int i = 0; i < N_CITIES; i++) if (occ[i] != 1) return 0;
        return 1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tb_x[i] = 0;
            tb_y[i] = 0;
        end
    endtask

    task automatic write_city(input int a, input int x, input int y);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = GENE_W'(a);
        cfg_x    = COORD_W'(x);
        cfg_y    = COORD_W'(y);
        @(negedge clk);
        cfg_we = 1'b0;
        if (a < N_CITIES) begin
            tb_x[a] = x;
            tb_y[a] = y;
        end
    endtask

    task automatic load_mode(input int mode);
        do_reset();
        if (mode == 1) for (int k = 0; k < N_CITIES; k++) write_city(k, k, 0);
        if (mode == 2) for (int k = 0; k < N_CITIES; k++) write_city(k, k, 2 * k);
    endtask

    // Launch one evaluation; lat = edges after the accepting edge until done.
    task automatic run_eval(input string nm, input logic [CHROM_W-1:0] c,
                            output int lat);
        lat = -1;
        @(negedge clk);
        chrom = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({nm, "_busy_run"}, int'(busy), 1);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_done_seen"}, int'(lat > 0), 1);
        if (lat > 0) begin
            @(posedge clk);
            #1;
            chk({nm, "_done_pulse"}, int'(done), 0);
            chk({nm, "_busy_end"}, int'(busy), 0);
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int t1;
        int t2;
        int perm [N_CITIES];
        int j;
        int tmp;
        logic [CHROM_W-1:0] c;

        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_x    = '0;
        cfg_y    = '0;
        start    = 1'b0;
        chrom    = '0;

        vecs[0] = '{"empty_ident", 0, ident(), 0, 1};
        vecs[1] = '{"line_ident", 1, ident(), 58, 1};
        vecs[2] = '{"line_rev", 1, reversed(), 58, 1};
        vecs[3] = '{"diag_swap", 2,
                    set_gene(set_gene(ident(), 0, 29), 29, 0), 336, 1};
        vecs[4] = '{"dup_gene5", 1, set_gene(ident(), 5, 7), 60, 0};
        vecs[5] = '{"gene3_31", 1, set_gene(ident(), 3, 31), 62, 0};
        vecs[6] = '{"all_same", 1, '0, 0, 0};
        vecs[7] = '{"diag_ident", 2, ident(), 174, 1};
        for (int k = 0; k < N_CITIES; k++) vecs[6].c = set_gene(vecs[6].c, k, 5);

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_distance", int'(distance), 0);
        chk("rst_valid", int'(valid), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            load_mode(vecs[v].mode);
            run_eval(vecs[v].name, vecs[v].c, lat);
            chk({vecs[v].name, "_dist"}, int'(distance), vecs[v].exp_d);
            chk({vecs[v].name, "_valid"}, int'(valid), vecs[v].exp_v);
            chk({vecs[v].name, "_model"}, vecs[v].exp_d, model_dist(vecs[v].c));
            // done expected in cycle N_CITIES+2, i.e. N_CITIES+1 edges later
            if (v == 0) chk("latency", lat, N_CITIES + 1);
        end

        // start and table write while busy are both ignored
        load_mode(1);
        @(negedge clk);
        chrom = ident();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            start  = (k == 5 || k == 10);
            cfg_we = (k == 5 || k == 10);
            cfg_addr = '0;
            cfg_x    = 8'd200;
            cfg_y    = 8'd200;
        end
        start  = 1'b0;
        cfg_we = 1'b0;
        chk("busy_ignore_done_count", ndone, 1);
        chk("busy_ignore_dist", int'(distance), 58);
        run_eval("table_frozen", ident(), lat);
        chk("table_frozen_dist", int'(distance), 58);

        // write and start in the same idle cycle: new entry is used
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_x    = 8'd10;
        cfg_y    = 8'd0;
        chrom    = ident();
        start    = 1'b1;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        start   = 1'b0;
        tb_x[0] = 10;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("same_cycle_done", lat, N_CITIES + 1);
        chk("same_cycle_dist", int'(distance), 56);
        chk("same_cycle_model", int'(distance), model_dist(ident()));

        // start held high: back-to-back runs every 33 cycles
        @(negedge clk);
        chrom = reversed();
        start = 1'b1;
        ndone = 0;
        t1 = 0;
        t2 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) t1 = k;
                if (ndone == 2) t2 = k;
            end
        end
        start = 1'b0;
        chk("held_start_count", ndone, 3);
        chk("held_start_period", t2 - t1, 33);
        repeat (40) @(posedge clk);

        // reset mid-run aborts and clears the table
        @(negedge clk);
        chrom = ident();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_distance", int'(distance), 0);
        chk("abort_valid", int'(valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tb_x[i] = 0;
            tb_y[i] = 0;
        end
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_eval("abort_table", reversed(), lat);
        chk("abort_table_dist", int'(distance), 0);
        chk("abort_table_valid", int'(valid), 1);

        // randomized tables and tours against the model
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < N_CITIES; k++)
                write_city(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            write_city(30 + int'($urandom_range(0, 1)), 99, 99);
            for (int k = 0; k < N_CITIES; k++) perm[k] = k;
            for (int k = N_CITIES - 1; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                tmp = perm[k];
                perm[k] = perm[j];
                perm[j] = tmp;
            end
            if (it % 3 == 1) perm[$urandom_range(0, 29)] = int'($urandom_range(0, 31));
            c = '0;
            for (int k = 0; k < N_CITIES; k++) c = set_gene(c, k, perm[k]);
            run_eval("rand", c, lat);
            chk("rand_dist", int'(distance), model_dist(c));
            chk("rand_valid", int'(valid), model_valid(c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
